// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a 104-bit emesh packet FIFO; stalls sources while near full.
// Optional burst locking is enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 104
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    access_in,
  input  logic [N*DW-1:0] packet_in,
  output logic [N-1:0]    wait_out,
`ifdef FIFO_ARB_BURST_EN
  input  logic [N-1:0]    lock_in,
`endif
  input  logic            fifo_full,
  input  logic            fifo_prog_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          blocked;
  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] sel;
  logic [PW-1:0] sel_inc;
  logic          sel_valid;
  logic          accept;
  logic [N-1:0]  grant;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;
  int            idx;

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t   state, state_next;
  logic [PW-1:0] owner, owner_next;
`endif

  assign blocked = fifo_full | fifo_prog_full;

  // Rotating priority search: first active requester at or after rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && access_in[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    sel       = winner;
    sel_valid = found;
`ifdef FIFO_ARB_BURST_EN
    if (state == LOCKED) begin
      sel       = owner;
      sel_valid = access_in[owner];
    end
`endif
    grant = '0;
    if (sel_valid && !blocked && !rst) grant[sel] = 1'b1;
  end

  assign accept   = |grant;
  assign wait_out = access_in & ~grant;
  assign sel_inc  = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);

`ifdef FIFO_ARB_BURST_EN
  // While LOCKED the pointer is frozen; it moves past the owner when the burst ends.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (accept) begin
          rr_next = sel_inc;
          if (lock_in[sel]) begin
            state_next = LOCKED;
            owner_next = sel;
          end
        end
      end
      LOCKED: begin
        if (!blocked && (!access_in[owner] || (accept && !lock_in[owner]))) begin
          state_next = IDLE;
          rr_next    = sel_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  always_comb begin
    rr_next = rr_ptr;
    if (accept) rr_next = sel_inc;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      rr_ptr     <= '0;
`ifdef FIFO_ARB_BURST_EN
      state      <= IDLE;
      owner      <= '0;
`endif
    end else begin
      fifo_wr_en <= accept;
      if (accept) fifo_din <= packet_in[int'(sel)*DW +: DW];
      rr_ptr     <= rr_next;
`ifdef FIFO_ARB_BURST_EN
      state      <= state_next;
      owner      <= owner_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised self-checking bench for fifo_wr_arbiter against a rotating-priority reference model.
// Exercises burst locking when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 104;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    access_in;
  logic [N*DW-1:0] packet_in;
  logic [N-1:0]    wait_out;
  logic [N-1:0]    lock_drv;
  logic            fifo_full;
  logic            fifo_prog_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;

  fifo_wr_arbiter #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .access_in      (access_in),
    .packet_in      (packet_in),
    .wait_out       (wait_out),
`ifdef FIFO_ARB_BURST_EN
    .lock_in        (lock_drv),
`endif
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] pkts [N];
  int            m_ptr    = 0;
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  logic [N-1:0]  exp_wait, obs_wait;
  logic          exp_wr_en, obs_wr_en;
  logic [DW-1:0] exp_din = '0;
  logic [DW-1:0] obs_din;

  function automatic int model_pick(input logic [N-1:0] acc, input int ptr);
    for (int d = 0; d < N; d++)
      if (acc[(ptr + d) % N]) return (ptr + d) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Drives one cycle (entered at posedge+1), updates the model, samples the outputs.
  task automatic step(input logic [N-1:0] acc, input logic full, input logic pfull);
    int w;
    w = -1;
    access_in      = acc;
    fifo_full      = full;
    fifo_prog_full = pfull;
    for (int i = 0; i < N; i++) packet_in[i*DW +: DW] = pkts[i];
    #2;
    obs_wait = wait_out;
    if (rst) begin
      m_ptr    = 0;
      m_locked = 1'b0;
    end else if (!(full || pfull)) begin
      if (m_locked) begin
        if (acc[m_owner]) w = m_owner;
        if (!acc[m_owner] || !lock_drv[m_owner]) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
        end
      end else begin
        w = model_pick(acc, m_ptr);
        if (w >= 0) begin
          m_ptr = (w + 1) % N;
          if (BURST && lock_drv[w]) begin
            m_locked = 1'b1;
            m_owner  = w;
          end
        end
      end
    end
    exp_wait = acc;
    if (w >= 0) exp_wait[w] = 1'b0;
    exp_wr_en = (w >= 0);
    if (rst) exp_din = '0;
    else if (w >= 0) exp_din = pkts[w];
    @(posedge clk);
    #1;
    obs_wr_en = fifo_wr_en;
    obs_din   = fifo_din;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lock_drv = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
      step(N'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (obs_wait !== exp_wait) begin
        n_fail++;
        $display("[TB] FAIL reset_wait: got %b expected %b", obs_wait, exp_wait);
      end
      n_checks++;
      if (obs_wr_en !== 1'b0 || obs_din !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_regs: wr_en %b din %h expected 0/0", obs_wr_en, obs_din);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 1'b0, 1'b0);
      n_checks++;
      if (obs_wait !== exp_wait) begin
        n_fail++;
        $display("[TB] FAIL rr_wait[%0d]: got %b expected %b", c, obs_wait, exp_wait);
      end
      n_checks++;
      if (obs_wr_en !== 1'b1 || obs_din !== pkts[order[c]]) begin
        n_fail++;
        $display("[TB] FAIL rr_order[%0d]: wr_en %b din %h expected source %0d din %h",
                 c, obs_wr_en, obs_din, order[c], pkts[order[c]]);
      end
    end
    step(4'b0000, 1'b0, 1'b0);
    n_checks++;
    if (obs_wr_en !== 1'b0 || obs_din !== exp_din) begin
      n_fail++;
      $display("[TB] FAIL rr_idle_hold: wr_en %b din %h expected 0 din %h", obs_wr_en, obs_din, exp_din);
    end
  endtask

  task automatic test_prog_full_hold();
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    for (int c = 0; c < 8; c++) begin
      step(4'b0101, 1'b0, (c >= 2 && c < 6));
      n_checks++;
      if (obs_wait !== exp_wait || obs_wr_en !== exp_wr_en || obs_din !== exp_din) begin
        n_fail++;
        $display("[TB] FAIL pfull_hold[%0d]: wait %b wr_en %b din %h expected %b %b %h",
                 c, obs_wait, obs_wr_en, obs_din, exp_wait, exp_wr_en, exp_din);
      end
    end
  endtask

  task automatic test_single();
    pkts[2] = 104'hDEAD_BEEF_CAFE_F00D_1234_5678_9A;
    step(4'b0100, 1'b0, 1'b0);
    n_checks++;
    if (obs_wait !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_wait: got %b expected 0000", obs_wait);
    end
    n_checks++;
    if (obs_wr_en !== 1'b1 || obs_din !== 104'hDEAD_BEEF_CAFE_F00D_1234_5678_9A) begin
      n_fail++;
      $display("[TB] FAIL single_data: wr_en %b din %h expected 1 DEADBEEF...", obs_wr_en, obs_din);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    rst = 1'b1;
    step(4'b1111, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (obs_wr_en !== 1'b0 || obs_din !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_regs: wr_en %b din %h expected 0/0", obs_wr_en, obs_din);
    end
    n_checks++;
    if (obs_wait !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL midreset_wait: got %b expected 1111", obs_wait);
    end
    step(4'b1010, 1'b0, 1'b0);
    n_checks++;
    if (obs_wait !== 4'b1000 || obs_din !== pkts[1]) begin
      n_fail++;
      $display("[TB] FAIL midreset_first_grant: wait %b din %h expected 1000 source 1", obs_wait, obs_din);
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
      step(N'($urandom) | 4'b0001, 1'b1, 1'b0);
      n_checks++;
      if (obs_wr_en !== 1'b0 || obs_wait !== access_in || obs_din !== exp_din) begin
        n_fail++;
        $display("[TB] FAIL full_block[%0d]: wr_en %b wait %b din %h expected 0 %b %h",
                 c, obs_wr_en, obs_wait, obs_din, access_in, exp_din);
      end
    end
  endtask

  task automatic test_burst();
    int order [5];
    if (BURST) order = '{1, 1, 1, 1, 2};
    else       order = '{1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    lock_drv = '0;
    step(4'b0001, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      lock_drv = (c < 3) ? 4'b0010 : 4'b0000;
      step(4'b1111, 1'b0, 1'b0);
      n_checks++;
      if (obs_wr_en !== 1'b1 || obs_din !== pkts[order[c]] || obs_wait !== exp_wait) begin
        n_fail++;
        $display("[TB] FAIL burst_beat[%0d]: wr_en %b wait %b din %h expected source %0d wait %b",
                 c, obs_wr_en, obs_wait, obs_din, order[c], exp_wait);
      end
    end
    lock_drv = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    logic         full, pfull;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (access_in[i] !== 1'b1 || wait_out[i] !== 1'b1) pkts[i] = rand_pkt();
      acc   = N'($urandom);
      full  = ($urandom_range(0, 15) == 0);
      pfull = ($urandom_range(0, 7) == 0);
      lock_drv = BURST ? N'($urandom) : '0;
      step(acc, full, pfull);
      n_checks++;
      if (obs_wait !== exp_wait || obs_wr_en !== exp_wr_en || obs_din !== exp_din) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: wait %b wr_en %b din %h expected %b %b %h",
                 c, obs_wait, obs_wr_en, obs_din, exp_wait, exp_wr_en, exp_din);
      end
    end
    lock_drv = '0;
  endtask

  initial begin
    rst            = 1'b1;
    access_in      = '0;
    packet_in      = '0;
    lock_drv       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_prog_full_hold();
    test_single();
    test_reset_mid();
    test_full();
    test_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
